// File: rtl/ram_pkg.sv
// ram_pkg: shared sizing constants and word/address types for the 1k x 8 RAM
//   DATA_WIDTH  width of one memory word
//   ADDR_WIDTH  address bus width
//   DEPTH       number of words, the full 2^ADDR_WIDTH space
package ram_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 10;
   localparam int DEPTH      = 1 << ADDR_WIDTH;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/ram_array.sv
// ram_array: bare storage, clocked write port and combinational read port
//   clk    in   write clock
//   we     in   write enable, already qualified by the caller
//   addr   in   shared read/write word address
//   wdata  in   write data
//   rdata  out  mem[addr], unqualified
module ram_array
   import ram_pkg::*;
(
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   data_t mem_q [DEPTH];
   // contents survive reset, so the array has no reset term
   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end
   assign rdata = mem_q[addr];
endmodule

// File: rtl/single_port_ram_1k8.sv
// single_port_ram_1k8: 1024 x 8 single-port RAM, sync write, async read, cs-gated
//   clk       in   write clock
//   rst       in   async active-high; forces data_out to 0 and blocks writes
//   addr      in   word address for read and write
//   data_in   in   write data
//   wr        in   1 = write, 0 = read
//   cs        in   chip select; 0 = idle
//   data_out  out  read data, 0 unless a qualified read is in progress
module single_port_ram_1k8
   import ram_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr,
   input  logic                  cs,
   output logic [DATA_WIDTH-1:0] data_out
);
   logic  we;
   logic  re;
   data_t rdata;
   always_comb begin
      we       = cs & wr & ~rst;
      re       = cs & ~wr & ~rst;
      // no write-through: output is zero on write cycles
      data_out = re ? rdata : '0;
   end
   ram_array u_array (
      .clk   (clk),
      .we    (we),
      .addr  (addr),
      .wdata (data_in),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_single_port_ram_1k8.sv
// tb_single_port_ram_1k8: directed self-checking bench for single_port_ram_1k8
module tb_single_port_ram_1k8;
   import ram_pkg::*;
   logic                  clk = 1'b0;
   logic                  rst;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  wr;
   logic                  cs;
   logic [DATA_WIDTH-1:0] data_out;
   logic [DATA_WIDTH-1:0] model [DEPTH];
   int errors = 0;
   int checks = 0;

   single_port_ram_1k8 dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .data_in  (data_in),
      .wr       (wr),
      .cs       (cs),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic write_word(input logic [9:0] a, input logic [7:0] d);
      addr = a; data_in = d; wr = 1'b1; cs = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic read_check(input string tag, input logic [9:0] a, input logic [7:0] exp);
      addr = a; wr = 1'b0; cs = 1'b1;
      #2 check(tag, data_out, exp);
   endtask

   initial begin
      int r;
      logic [9:0] ra;
      r = $urandom(32'h1234_5678);
      rst = 1'b1; addr = '0; data_in = '0; wr = 1'b0; cs = 1'b1;
      #2 check("reset_out", data_out, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         write_word(10'(k), 8'((2 * k) % 256));
         model[k] = 8'((2 * k) % 256);
      end
      read_check("rd_5", 10'd5, 8'd10);
      read_check("rd_200", 10'd200, 8'd144);
      read_check("rd_1023", 10'd1023, 8'd254);
      // deselected write must not land
      addr = 10'd7; data_in = 8'hAA; wr = 1'b1; cs = 1'b0;
      #2 check("desel_out", data_out, 8'h00);
      @(posedge clk); #1;
      read_check("desel_rd_7", 10'd7, 8'd14);
      cs = 1'b0; wr = 1'b0;
      addr = 10'd5;   #2 check("cs0_a5", data_out, 8'h00);
      addr = 10'd200; #2 check("cs0_a200", data_out, 8'h00);
      addr = 10'd1023; #2 check("cs0_a1023", data_out, 8'h00);
      cs = 1'b1; wr = 1'b1; addr = 10'd5; data_in = 8'd10;
      #2 check("wr_cycle_out", data_out, 8'h00);
      @(posedge clk); #1;
      check("wr_cycle_post", data_out, 8'h00);
      // async reset between edges
      read_check("pre_rst_rd_5", 10'd5, 8'd10);
      rst = 1'b1;
      #1 check("rst_async_out", data_out, 8'h00);
      addr = 10'd3; data_in = 8'h55; wr = 1'b1; cs = 1'b1;
      @(posedge clk); #1;
      check("rst_wr_out", data_out, 8'h00);
      rst = 1'b0;
      read_check("rst_retain_3", 10'd3, 8'd6);
      write_word(10'd9, 8'h3C);
      model[9] = 8'h3C;
      read_check("b2b_rd_9", 10'd9, 8'h3C);
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         ra = 10'($urandom_range(0, DEPTH - 1));
         read_check($sformatf("rand_%0d_a%0d", i, ra), ra, model[ra]);
         @(posedge clk); #1;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
